fp16_dot_accum: RTL and testbench
=================================

# fp16_dot_accum

- Streaming FP16 dot-product sequencer placed directly upstream of `FP16FMA`.
- Accepts a stream of (a, b) element pairs and issues one fused multiply-add per element to the FMA, using the running partial sum as the addend.
- Hides the FMA's 4-cycle latency by rotating over four interleaved partial sums, then reduces them through the same FMA and presents one FP16 result per vector.

## Interface
- `FMA_LAT`, default 4: in_valid→out_valid latency of the attached `FP16FMA`. Only 4 is supported; the slot count equals `FMA_LAT`.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: element pair valid.
- `in_ready` output 1: element pair accepted when `in_valid & in_ready`.
- `in_a` input 16: FP16 operand a.
- `in_b` input 16: FP16 operand b.
- `in_last` input 1: marks the final element of the current vector.
- `res_valid` output 1: dot-product result valid.
- `res_ready` input 1: result consumed.
- `res_data` output 16: FP16 dot product.
- `fma_in_valid` output 1: FMA operand strobe.
- `fma_a` output 16: FMA operand a.
- `fma_b` output 16: FMA operand b.
- `fma_c` output 16: FMA addend c.
- `fma_out` input 16: FMA result; `fma_out_valid` is deliberately not an input.

## Operation
- **State registers.** Four slot registers S0..S3 (reset 16'h0000), a 2-bit round-robin pointer `ptr`, and a 4-stage tag pipe. Each tag-pipe stage holds {valid, tag[2:0]}: tags 0–3 = slot, 4 = R01, 5 = R23, 6 = RES.
- **Result capture.** The tag pipe alone decides when `fma_out` is captured. The FMA's out_valid chain has no reset, so it is never used.
- **States.**
  - ACCUM: `in_ready` = 1. On accept, drive `fma_in_valid`=1, `fma_a`=`in_a`, `fma_b`=`in_b`, `fma_c`=slot[ptr]; push tag `ptr`; `ptr`++.
  - Bypass: if the tag-pipe output is valid and its tag equals `ptr` this cycle, `fma_c` = `fma_out`.
  - Accept with `in_last` → DRAIN.
  - DRAIN: `in_ready` = 0. Go to RED_A when the only valid tag-pipe entry (if any) is the one returning this cycle.
  - RED_A: issue a=S0, b=16'h3C00, c=S1, tag R01 → RED_B.
  - RED_B: issue a=S2, b=16'h3C00, c=S3, tag R23 → WAIT1.
  - WAIT1: go to RED_C when R23 returns this cycle.
  - RED_C: issue a=R01, b=16'h3C00, c=R23 (R23 bypassed from `fma_out` if needed), tag RES → WAIT2.
  - WAIT2: capture RES into `res_data` → DONE.
  - DONE: `res_valid` = 1. On `res_ready`: clear S0..S3 to 0, `ptr` = 0, → ACCUM.
- **Capture.** A returning tag 0–3 writes `fma_out` into slot[tag]. R01 and R23 are held in S0 and S2.
- **FMA outputs.** `fma_in_valid` is 0 in every state and cycle except the issue cycles. `fma_a`/`fma_b`/`fma_c` are don't-care when `fma_in_valid` is 0.
- **Reset.** `rst` in any state, including mid-vector or mid-reduction:
  - state = ACCUM, slots = 0, `ptr` = 0, all tag-pipe valids = 0;
  - in-flight FMA results are discarded.
- **Outputs during `rst`:** `in_ready` 0, `res_valid` 0, `res_data` 16'h0000, `fma_in_valid` 0.

## Timing
- **Issue.** Combinational from the accept handshake: an element accepted in cycle T is presented to the FMA in cycle T and returns in T+4.
- **Throughput.** One element per cycle sustained. Bubbles are allowed anywhere.
- **Latency.** Last element accepted in cycle T → `res_valid` high in T+16, independent of vector length and bubbles:
  - DRAIN → RED_A at end of T+4;
  - RED_A in T+5, RED_B in T+6;
  - R01/R23 return in T+9/T+10;
  - RED_C in T+11, RES returns in T+15.
- **Vector restart.** `in_ready` rises in the cycle after the result handshake.
- **Backpressure.** `res_data` is held stable while `res_valid` is high and `res_ready` is low.
- **Lengths.** Vectors shorter than 4 leave unused slots at +0, which the reduction adds harmlessly. Vector length is unbounded.

## Structure
- **Shared package `fp16_pkg`:**
  - FP16_ZERO = 16'h0000, FP16_ONE = 16'h3C00;
  - FMA_LAT = 4;
  - tag encodings TAG_R01 / TAG_R23 / TAG_RES;
  - state enum.
- **Sub-module `fma_tag_pipe`:** a 4-stage {valid, tag} shift register with synchronous clear. It exposes the output stage plus an "any valid in stages 0..2" flag used by the DRAIN/WAIT exits.
- **Integration:** the top-level test wrapper instantiates `fp16_dot_accum` feeding `FP16FMA` at 600 MHz.

## Test plan
- **4-element vector:** a = {3C00, 4000, 4200, 4400}, b = 3C00 ×4, back-to-back, last on element 4 → `res_data` = 16'h4900 (10.0), `res_valid` exactly 16 cycles after last.
- **Single element:** a = 4000, b = 4200, last → 16'h4600 (6.0). Slots 1–3 remain 0 and do not perturb the result.
- **Slot reuse:** 8 back-to-back 1.0×1.0 → 16'h4800 (8.0). This proves the bypass on slot reuse at distance 4.
- **Bubbles:** same as the 8-element case with a random `in_valid` gap pattern → 16'h4800, latency still 16 cycles from last.
- **Backpressure:** hold `res_ready` = 0 for 10 cycles → `res_valid` and `res_data` stay stable, `in_ready` stays 0. Release → a new vector is accepted the next cycle.
- **Reset mid-reduction:** assert `rst` mid-reduction (WAIT1), then send 1.0×1.0 with last → 16'h3C00. No stale in-flight result is captured.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, FMA tag encodings and sequencer states used by the
// dot-product accumulator and its tag pipe.
package fp16_pkg;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam int          FMA_LAT   = 4;

  // Tags 0..3 name a partial-sum slot; the rest name reduction results.
  localparam logic [2:0]  TAG_R01   = 3'd4;
  localparam logic [2:0]  TAG_R23   = 3'd5;
  localparam logic [2:0]  TAG_RES   = 3'd6;

  typedef enum logic [2:0] {
    ST_ACCUM = 3'd0,
    ST_DRAIN = 3'd1,
    ST_RED_A = 3'd2,
    ST_RED_B = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RED_C = 3'd5,
    ST_WAIT2 = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/fp16_dot_accum_if.sv
// Element stream, result stream and FMA operand/result signals of the
// dot-product sequencer; slave is the sequencer side.
interface fp16_dot_accum_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        fma_in_valid;
  logic [15:0] fma_a;
  logic [15:0] fma_b;
  logic [15:0] fma_c;
  logic [15:0] fma_out;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready, fma_out,
    input  in_ready, res_valid, res_data, fma_in_valid, fma_a, fma_b, fma_c
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready, fma_out,
    output in_ready, res_valid, res_data, fma_in_valid, fma_a, fma_b, fma_c
  );

endinterface

// File: rtl/fma_tag_pipe.sv
// Shadow of the FMA pipeline: a {valid, tag} shift register whose output stage
// lines up with the FMA result of the operation issued DEPTH cycles earlier.
module fma_tag_pipe #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       push_valid,
  input  logic [2:0] push_tag,
  output logic       out_valid,
  output logic [2:0] out_tag,
  output logic       busy
);

  logic [DEPTH-1:0]      vld_r;
  logic [DEPTH-1:0][2:0] tag_r;

  // Shift one stage per cycle; clear drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_r <= {DEPTH{1'b0}};
      tag_r <= {DEPTH{3'd0}};
    end else begin
      vld_r <= {vld_r[DEPTH-2:0], push_valid};
      tag_r <= {tag_r[DEPTH-2:0], push_tag};
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_tag   = tag_r[DEPTH-1];
  assign busy      = |vld_r[DEPTH-2:0];

endmodule

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 dot-product sequencer: four interleaved partial sums hide the
// FMA latency, then three issues through the same FMA reduce them to one result.
module fp16_dot_accum #(
  parameter int FMA_LAT = fp16_pkg::FMA_LAT
) (
  input  logic            clk,
  input  logic            rst,
  fp16_dot_accum_if.slave bus
);
  import fp16_pkg::*;

  state_t      state_r;
  logic [15:0] slot_r [4];
  logic [1:0]  ptr_r;
  logic [15:0] res_r;

  logic        ret_valid_s;
  logic [2:0]  ret_tag_s;
  logic        pipe_busy_s;
  logic        ret_r23_s;
  logic        issue_s;
  logic        fire_s;
  logic        accept_s;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [15:0] c_s;
  logic [2:0]  tag_s;

  fma_tag_pipe #(.DEPTH(FMA_LAT)) u_tag_pipe (
    .clk        (clk),
    .clr        (rst),
    .push_valid (fire_s),
    .push_tag   (tag_s),
    .out_valid  (ret_valid_s),
    .out_tag    (ret_tag_s),
    .busy       (pipe_busy_s)
  );

  assign ret_r23_s = ret_valid_s && (ret_tag_s == TAG_R23);

  // Operand select for the single FMA issue port.
  always_comb begin
    issue_s = 1'b0;
    a_s     = bus.in_a;
    b_s     = bus.in_b;
    c_s     = slot_r[ptr_r];
    tag_s   = {1'b0, ptr_r};
    case (state_r)
      ST_ACCUM: begin
        issue_s = bus.in_valid;
        // Slot reuse at distance FMA_LAT: its new value is on fma_out right now.
        if (ret_valid_s && (ret_tag_s == {1'b0, ptr_r})) begin
          c_s = bus.fma_out;
        end else begin
          c_s = slot_r[ptr_r];
        end
      end
      ST_RED_A: begin
        issue_s = 1'b1;
        a_s     = slot_r[0];
        b_s     = FP16_ONE;
        c_s     = slot_r[1];
        tag_s   = TAG_R01;
      end
      ST_RED_B: begin
        issue_s = 1'b1;
        a_s     = slot_r[2];
        b_s     = FP16_ONE;
        c_s     = slot_r[3];
        tag_s   = TAG_R23;
      end
      ST_RED_C: begin
        issue_s = 1'b1;
        a_s     = slot_r[0];
        b_s     = FP16_ONE;
        tag_s   = TAG_RES;
        if (ret_r23_s) begin
          c_s = bus.fma_out;
        end else begin
          c_s = slot_r[2];
        end
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  assign fire_s           = issue_s && !rst;
  assign accept_s         = bus.in_valid && bus.in_ready;
  assign bus.in_ready     = (state_r == ST_ACCUM) && !rst;
  assign bus.res_valid    = (state_r == ST_DONE) && !rst;
  assign bus.res_data     = rst ? FP16_ZERO : res_r;
  assign bus.fma_in_valid = fire_s;
  assign bus.fma_a        = a_s;
  assign bus.fma_b        = b_s;
  assign bus.fma_c        = c_s;

  // Result capture by returning tag, plus the sequencing FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
      ptr_r   <= 2'd0;
      res_r   <= FP16_ZERO;
      for (int i = 0; i < 4; i++) begin
        slot_r[i] <= FP16_ZERO;
      end
    end else begin
      if (ret_valid_s) begin
        case (ret_tag_s)
          3'd0, 3'd1, 3'd2, 3'd3: slot_r[ret_tag_s[1:0]] <= bus.fma_out;
          TAG_R01:                slot_r[0]              <= bus.fma_out;
          TAG_R23:                slot_r[2]              <= bus.fma_out;
          TAG_RES:                res_r                  <= bus.fma_out;
          default:                res_r                  <= res_r;
        endcase
      end
      case (state_r)
        ST_ACCUM: begin
          if (accept_s) begin
            ptr_r <= ptr_r + 2'd1;
            if (bus.in_last) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy_s) begin
            state_r <= ST_RED_A;
          end
        end
        ST_RED_A: state_r <= ST_RED_B;
        ST_RED_B: state_r <= ST_WAIT1;
        ST_WAIT1: begin
          if (ret_r23_s) begin
            state_r <= ST_RED_C;
          end
        end
        ST_RED_C: state_r <= ST_WAIT2;
        ST_WAIT2: begin
          if (ret_valid_s && (ret_tag_s == TAG_RES)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_r <= ST_ACCUM;
            ptr_r   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
              slot_r[i] <= FP16_ZERO;
            end
          end
        end
        default: state_r <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_dot_accum.sv
// Bench for fp16_dot_accum: a 4-cycle integer-exact FP16 FMA model sits behind
// the sequencer; results are compared with a plain sum of products.
module tb_fp16_dot_accum;

  logic clk = 1'b0;
  logic rst;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  localparam logic [15:0] POISON = 16'h6400;

  fp16_dot_accum_if ifc ();

  fp16_dot_accum #(.FMA_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FP16 <-> integer for values that are exact integers.
  function automatic int f2i(input logic [15:0] h);
    int e, m, v;
    if (h[14:10] == 5'd0) return 0;
    e = int'(h[14:10]) - 15;
    m = 1024 + int'(h[9:0]);
    if (e < 0) v = 0;
    else if (e >= 10) v = m << (e - 10);
    else v = m >> (10 - e);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] i2f(input int n);
    int mag, e;
    logic [15:0] r;
    if (n == 0) return 16'h0000;
    mag = (n < 0) ? -n : n;
    e = 0;
    for (int k = 0; k < 31; k++) if (mag >= (1 << k)) e = k;
    r[15]    = (n < 0);
    r[14:10] = 5'(e + 15);
    if (e >= 10) r[9:0] = 10'(mag >> (e - 10));
    else r[9:0] = 10'(mag << (10 - e));
    return r;
  endfunction

  // FMA model: result appears on fma_out exactly four cycles after issue.
  logic [15:0] fpipe [4];
  always @(posedge clk) begin
    fpipe[0] <= ifc.fma_in_valid
                ? i2f(f2i(ifc.fma_a) * f2i(ifc.fma_b) + f2i(ifc.fma_c)) : POISON;
    for (int i = 1; i < 4; i++) fpipe[i] <= fpipe[i-1];
  end
  assign ifc.fma_out = fpipe[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] qa [$];
  logic [15:0] qb [$];

  function automatic logic [15:0] ref_dot();
    int s = 0;
    for (int i = 0; i < qa.size(); i++) s += f2i(qa[i]) * f2i(qb[i]);
    return i2f(s);
  endfunction

  task automatic send_vec(input bit bubbles, output int t_last);
    t_last = cyc;
    for (int i = 0; i < qa.size(); i++) begin
      if (bubbles) begin
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          check("bubble_fma_idle", ifc.fma_in_valid, 1'b0);
        end
      end
      ifc.in_valid = 1'b1;
      ifc.in_a     = qa[i];
      ifc.in_b     = qb[i];
      ifc.in_last  = (i == qa.size() - 1);
      #1;
      check("in_ready", ifc.in_ready, 1'b1);
      if (i == 0) begin
        check("first_fma_valid", ifc.fma_in_valid, 1'b1);
        check("first_fma_a", ifc.fma_a, qa[0]);
        check("first_fma_b", ifc.fma_b, qb[0]);
        check("first_fma_c", ifc.fma_c, 16'h0000);
      end
      t_last = cyc;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp, input int t_last,
                            input int hold);
    int n = 0;
    while (ifc.res_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, cyc - t_last, 32'd16);
    check({tag, "_data"}, ifc.res_data, exp);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, ifc.res_valid, 1'b1);
      check({tag, "_hold_data"}, ifc.res_data, exp);
      check({tag, "_hold_in_ready"}, ifc.in_ready, 1'b0);
    end
    ifc.res_ready = 1'b1;
    @(posedge clk); #1;
    ifc.res_ready = 1'b0;
    check({tag, "_restart_in_ready"}, ifc.in_ready, 1'b1);
    check({tag, "_restart_res_valid"}, ifc.res_valid, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int len;
    rst           = 1'b1;
    ifc.in_valid  = 1'b1;
    ifc.in_a      = 16'h3C00;
    ifc.in_b      = 16'h3C00;
    ifc.in_last   = 1'b0;
    ifc.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ifc.in_ready, 1'b0);
    check("rst_res_valid", ifc.res_valid, 1'b0);
    check("rst_res_data", ifc.res_data, 16'h0000);
    check("rst_fma_valid", ifc.fma_in_valid, 1'b0);
    rst          = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("idle_in_ready", ifc.in_ready, 1'b1);
    check("idle_res_valid", ifc.res_valid, 1'b0);

    qa = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    qb = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    send_vec(1'b0, t);
    get_result("vec4", 16'h4900, t, 0);

    qa = '{16'h4000};
    qb = '{16'h4200};
    send_vec(1'b0, t);
    get_result("single", 16'h4600, t, 0);

    qa = '{8{16'h3C00}};
    qb = '{8{16'h3C00}};
    send_vec(1'b0, t);
    get_result("reuse8", 16'h4800, t, 10);

    send_vec(1'b1, t);
    get_result("bubbles8", 16'h4800, t, 0);

    for (int v = 0; v < 16; v++) begin
      qa.delete();
      qb.delete();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        qa.push_back(i2f(int'($urandom_range(0, 14)) - 7));
        qb.push_back(i2f(int'($urandom_range(0, 14)) - 7));
      end
      send_vec(1'($urandom_range(0, 1)), t);
      get_result("random", ref_dot(), t, int'($urandom_range(0, 3)));
    end

    // Reset while the R01/R23 reduction issues are still in flight.
    qa = '{16'h4400, 16'h4400, 16'h4400};
    qb = '{16'h4400, 16'h4400, 16'h4400};
    send_vec(1'b0, t);
    while (cyc < t + 8) begin
      @(posedge clk); #1;
    end
    rst          = 1'b1;
    ifc.in_valid = 1'b1;
    #1;
    check("midrst_in_ready", ifc.in_ready, 1'b0);
    check("midrst_res_valid", ifc.res_valid, 1'b0);
    check("midrst_res_data", ifc.res_data, 16'h0000);
    check("midrst_fma_valid", ifc.fma_in_valid, 1'b0);
    @(posedge clk); #1;
    rst          = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("midrst_after_in_ready", ifc.in_ready, 1'b1);
    qa = '{16'h3C00};
    qb = '{16'h3C00};
    send_vec(1'b0, t);
    get_result("after_rst", 16'h3C00, t, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
